// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared defaults and the framer state encoding used by the
//            audio_framer slice (audio_framer, preemph_filter).
// Contents : SAMPLE_W_DEF, FRAME_LEN_DEF, HOP_DEF, framer_state_t
// Revision : 1.0  initial release
// ============================================================================
package audio_pkg;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int FRAME_LEN_DEF = 16;
  localparam int HOP_DEF       = 8;

  // PRIME : collecting the first FRAME_LEN samples after reset
  // STEADY: collecting HOP new samples for the next overlapping frame
  // STALL : frame complete but the output register is still occupied
  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_STEADY = 2'd1,
    ST_STALL  = 2'd2
  } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/preemph_filter.sv
`default_nettype none
// ============================================================================
// Module   : preemph_filter
// Purpose  : First-order pre-emphasis y = sat(x - (x_prev - (x_prev >>> 5))),
//            i.e. y = x - 0.96875*x_prev. Combinational datapath plus the
//            raw previous-sample register. Only instantiated by audio_framer
//            when FRAMER_PREEMPH_EN is defined.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            x            - raw signed input sample
//            accept       - x is being accepted this cycle (updates x_prev)
//            y            - filtered, saturated sample
// Revision : 1.0  initial release
// ============================================================================
module preemph_filter #(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic                       accept,
  output logic signed [SAMPLE_W-1:0] y
);

  // Two guard bits: x - 0.97*x_prev spans roughly twice the sample range.
  localparam int IW = SAMPLE_W + 2;
  localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  logic signed [SAMPLE_W-1:0] x_prev;
  logic signed [IW-1:0]       x_ext;
  logic signed [IW-1:0]       p_ext;
  logic signed [IW-1:0]       diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev <= '0;
    end else if (accept) begin
      x_prev <= x;
    end
  end

  assign x_ext = {{2{x[SAMPLE_W-1]}}, x};
  assign p_ext = {{2{x_prev[SAMPLE_W-1]}}, x_prev};
  assign diff  = x_ext - (p_ext - (p_ext >>> 5));

  always_comb begin
    y = diff[SAMPLE_W-1:0];
    if (diff > SAT_MAX) begin
      y = SAT_MAX[SAMPLE_W-1:0];
    end else if (diff < SAT_MIN) begin
      y = SAT_MIN[SAMPLE_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_framer.sv
`default_nettype none
// ============================================================================
// Module   : audio_framer
// Purpose  : Collects a stream of signed audio samples into overlapping
//            frames of FRAME_LEN samples, advancing HOP samples per frame,
//            and presents each frame on a valid/ready output register.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            sample_in/valid/ready - input sample handshake
//            frame_data            - lane k = [k*SAMPLE_W +: SAMPLE_W], k=0 oldest
//            frame_valid/ready     - output frame handshake
//            overrun               - sticky: sample offered while not ready
// Config   : FRAMER_PREEMPH_EN - when defined, samples pass through
//            preemph_filter before being stored.
// Revision : 1.0  initial release
// ============================================================================
module audio_framer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,  // must be >= 2
  parameter int HOP       = HOP_DEF         // 1 <= HOP <= FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [FRAME_LEN*SAMPLE_W-1:0] frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          overrun
);

  localparam int FW    = FRAME_LEN * SAMPLE_W;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_PRIME  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_STEADY = CNT_W'(HOP - 1);

  framer_state_t      state;
  framer_state_t      next_state;
  logic [CNT_W-1:0]   cnt;
  logic [FW-1:0]      hist;
  logic [FW-1:0]      hist_next;
  logic [FW-1:0]      load_data;
  logic [SAMPLE_W-1:0] stored;
  logic               ready_en;
  logic               accept;
  logic               last;
  logic               load;
  logic               load_from_hist;
  logic               cnt_clr;

  // ready_en keeps sample_ready low while in reset and raises it on the
  // first clock edge after release.
  assign sample_ready = ready_en && (state != ST_STALL);
  assign accept       = sample_valid && sample_ready;

`ifdef FRAMER_PREEMPH_EN
  preemph_filter #(
    .SAMPLE_W (SAMPLE_W)
  ) u_preemph (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (sample_in),
    .accept (accept),
    .y      (stored)
  );
`else
  assign stored = sample_in;
`endif

  // Newest sample enters the top lane; lane 0 (oldest) drops out.
  assign hist_next = {stored, hist[FW-1:SAMPLE_W]};

  assign last = accept &&
                (cnt == ((state == ST_PRIME) ? LAST_PRIME : LAST_STEADY));

  // In STALL the history is already complete, so it is loaded directly;
  // otherwise the load must include the sample accepted on this same edge.
  assign load_data = load_from_hist ? hist : hist_next;

  always_comb begin
    next_state     = state;
    load           = 1'b0;
    load_from_hist = 1'b0;
    cnt_clr        = 1'b0;
    case (state)
      ST_PRIME, ST_STEADY: begin
        if (last) begin
          cnt_clr = 1'b1;
          if (!frame_valid || frame_ready) begin
            load       = 1'b1;
            next_state = ST_STEADY;
          end else begin
            next_state = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (frame_ready) begin
          load           = 1'b1;
          load_from_hist = 1'b1;
          next_state     = ST_STEADY;
        end
      end
      default: next_state = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PRIME;
      cnt         <= '0;
      hist        <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      state    <= next_state;
      ready_en <= 1'b1;
      if (accept) begin
        hist <= hist_next;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      // A load in the same cycle as a consume keeps frame_valid high.
      if (load) begin
        frame_data  <= load_data;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_framer
// Purpose  : Self-checking bench for audio_framer (default parameters).
//            A reference model builds expected frames into a queue; a
//            monitor pops and compares them on each frame handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_audio_framer;

  localparam int SW = 16;
  localparam int FL = 16;
  localparam int HP = 8;

  typedef logic [FL*SW-1:0] frame_t;

  typedef struct {
    int sample;
    bit valid;
    bit fready;
    bit acc;
    bit e_sready;
    bit e_fvalid;
    bit e_overrun;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  frame_t        frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          overrun;

  int compared   = 0;
  int mismatched = 0;
  int fv_cycles  = 0;

  frame_t exp_q[$];

  logic signed [SW-1:0] m_hist [FL];
  int m_cnt;
  bit m_primed;
  int m_xp;

  vec_t vecs [27];

  always #5 clk = ~clk;

  audio_framer #(
    .SAMPLE_W  (SW),
    .FRAME_LEN (FL),
    .HOP       (HP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .overrun      (overrun)
  );

  function automatic void chk(string nm, longint act, longint exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endfunction

  function automatic int store_val(int x);
`ifdef FRAMER_PREEMPH_EN
    int d;
    d = x - (m_xp - (m_xp >>> 5));
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < FL; k++) m_hist[k] = '0;
    m_cnt    = 0;
    m_primed = 0;
    m_xp     = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(int x);
    frame_t f;
    int     y;
    y    = store_val(x);
    m_xp = x;
    for (int k = 0; k < FL - 1; k++) m_hist[k] = m_hist[k+1];
    m_hist[FL-1] = SW'(y);
    m_cnt++;
    if (m_cnt == (m_primed ? HP : FL)) begin
      for (int k = 0; k < FL; k++) f[k*SW +: SW] = m_hist[k];
      exp_q.push_back(f);
      m_cnt    = 0;
      m_primed = 1;
    end
  endtask

  // Inputs change and outputs are checked 2 time units after the rising
  // edge; the monitor samples at the falling edge.
  always @(negedge clk) begin
    if (rst_n && frame_valid) fv_cycles++;
    if (rst_n && frame_valid && frame_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL frame_unexpected: got %h expected none", frame_data);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (frame_data !== e) begin
          mismatched++;
          $display("FAIL frame: got %h expected %h", frame_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    frame_ready  = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_sample_ready", sample_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_data_zero", (frame_data != '0), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", sample_ready, 1);
  endtask

  task automatic send(int x);
    sample_in    = SW'(x);
    sample_valid = 1'b1;
    model_accept(x);
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    int fv0;

    // Stall scenario: 16 samples with frame_ready=1, 8 more with
    // frame_ready=0, one refused offer, then two consuming cycles.
    for (int i = 0; i < 27; i++) begin
      int e;
      e = i + 1;
      vecs[i].sample    = e;
      vecs[i].valid     = (e <= 25);
      vecs[i].fready    = (e <= 16) || (e >= 26);
      vecs[i].acc       = (e <= 24);
      vecs[i].e_sready  = !(e == 24 || e == 25);
      vecs[i].e_fvalid  = (e >= 16) && (e <= 26);
      vecs[i].e_overrun = (e >= 25);
    end

    do_reset();

    // First frame 1..16, second frame 9..24, frame_ready held high.
    fv0 = fv_cycles;
    for (int i = 1; i <= 16; i++) begin
      send(i);
      if (i == 15) chk("no_early_frame", frame_valid, 0);
      if (i == 16) chk("frame1_latency", frame_valid, 1);
    end
    for (int i = 17; i <= 24; i++) begin
      send(i);
      if (i == 24) chk("frame2_latency", frame_valid, 1);
    end
    tick();
    tick();
    chk("frame_valid_idle", frame_valid, 0);
    chk("one_cycle_per_frame", fv_cycles - fv0, 2);
    chk("scoreboard_drained_a", exp_q.size(), 0);

    // Stall and overrun, table driven.
    do_reset();
    for (int i = 0; i < 27; i++) begin
      sample_in    = SW'(vecs[i].sample);
      sample_valid = vecs[i].valid;
      frame_ready  = vecs[i].fready;
      if (vecs[i].acc) model_accept(vecs[i].sample);
      tick();
      chk($sformatf("vec%0d_sample_ready", i + 1), sample_ready, vecs[i].e_sready);
      chk($sformatf("vec%0d_frame_valid", i + 1), frame_valid, vecs[i].e_fvalid);
      chk($sformatf("vec%0d_overrun", i + 1), overrun, vecs[i].e_overrun);
      if ((i + 1 == 25 || i + 1 == 26) && exp_q.size() > 0) begin
        compared++;
        if (frame_data !== exp_q[0]) begin
          mismatched++;
          $display("FAIL vec%0d_frame_data: got %h expected %h", i + 1, frame_data, exp_q[0]);
        end
      end
    end
    sample_valid = 1'b0;
    tick();
    chk("scoreboard_drained_stall", exp_q.size(), 0);

    // Reset mid-fill discards the partial frame.
    do_reset();
    for (int i = 201; i <= 210; i++) send(i);
    rst_n = 1'b0;
    model_reset();
    tick();
    chk("midfill_rst_frame_valid", frame_valid, 0);
    rst_n = 1'b1;
    tick();
    fv0 = fv_cycles;
    for (int i = 101; i <= 116; i++) send(i);
    tick();
    tick();
    chk("after_reset_one_frame", fv_cycles - fv0, 1);
    chk("after_reset_overrun", overrun, 0);
    chk("scoreboard_drained_rst", exp_q.size(), 0);

`ifdef FRAMER_PREEMPH_EN
    do_reset();
    for (int i = 0; i < 16; i++) send(320);
    chk("pe_const_lane0", frame_data[0 +: SW], 320);
    chk("pe_const_lane1", frame_data[SW +: SW], 10);
    chk("pe_const_lane15", frame_data[15*SW +: SW], 10);
    tick();
    do_reset();
    send(32767);
    send(-32768);
    for (int i = 0; i < 14; i++) send(0);
    chk("pe_sat_lane0", frame_data[0 +: SW], 16'h7fff);
    chk("pe_sat_lane1", frame_data[SW +: SW], 16'h8000);
    tick();
    chk("scoreboard_drained_pe", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_framer.md
AUDIO_FRAMER -- requirements
Module: audio_framer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame (FFT size).
REQ-003 SHALL have parameter HOP, default 8, new samples between frames; 1 <= HOP <= FRAME_LEN.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: sample_in  input  SAMPLE_W  signed audio sample.
REQ-008 SHALL have port: sample_valid  input  1  sample_in qualifier.
REQ-009 SHALL have port: sample_ready  output  1  framer accepts a sample this cycle.
REQ-010 SHALL have port: frame_data  output  FRAME_LEN*SAMPLE_W  lane k at [k*SAMPLE_W +: SAMPLE_W], k=0 oldest.
REQ-011 SHALL have port: frame_valid  output  1  frame_data holds an unconsumed frame.
REQ-012 SHALL have port: frame_ready  input  1  downstream FFT takes the frame.
REQ-013 SHALL have port: overrun  output  1  sticky; a sample was offered while sample_ready=0.

Function
REQ-014 SHALL accept a sample on a rising edge only when sample_valid && sample_ready, shifting it into a FRAME_LEN-deep history, with the oldest sample dropped.
REQ-015 SHALL implement the states PRIME (collect FRAME_LEN samples), STEADY (collect HOP samples) and STALL (frame complete, output register occupied).
REQ-016 SHALL, on reset, enter PRIME with the sample counter at 0.
REQ-017 SHALL, on completion of a frame's sample count, load the history into the output register if frame_valid=0 or frame_ready=1 that cycle; otherwise it SHALL go to STALL.
REQ-018 SHALL move from PRIME to STEADY after the first load, and from STEADY back to STEADY after each load, resetting the counter to 0.
REQ-019 SHALL, in STALL, drive sample_ready=0, load when frame_ready=1, then go to STEADY.
REQ-020 SHALL drive sample_ready=1 in PRIME and STEADY.
REQ-021 SHALL assert frame_valid in the cycle after the accepting edge of the completing sample (latency 1), hold it and frame_data stable until frame_valid && frame_ready, and support back-to-back load and consume in the same cycle.
REQ-022 SHALL set overrun on sample_valid && !sample_ready; overrun SHALL clear only on reset.
REQ-023 SHALL produce a first frame containing samples 1..FRAME_LEN and subsequent frames overlapping the previous one by FRAME_LEN-HOP samples.

Reset
REQ-024 SHALL, while rst_n=0, force: state PRIME, counter 0, history 0, frame_data 0, frame_valid 0, overrun 0, pre-emphasis memory 0; sample_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-025 SHALL, on reset mid-fill or mid-stall, discard the partial or pending frame; no frame_valid pulse SHALL result from pre-reset samples.

Configuration
REQ-026 SHALL, with FRAMER_PREEMPH_EN defined, store y = sat(x - (x_prev - (x_prev >>> 5))) instead of x. This uses 18-bit signed intermediates and saturates to the SAMPLE_W range. x_prev is the raw previous accepted sample.
REQ-027 SHALL, without FRAMER_PREEMPH_EN, store accepted samples unmodified with zero added logic or latency.

Structure
REQ-028 SHALL take SAMPLE_W, FRAME_LEN and HOP defaults and the state encoding (PRIME, STEADY, STALL) from shared package audio_pkg.
REQ-029 SHALL place pre-emphasis in sub-module preemph_filter (combinational datapath plus x_prev register), instantiated only under FRAMER_PREEMPH_EN.

Verification
REQ-030 SHALL cover: macro off, frame_ready=1, samples 1..16 -> frame_valid high one cycle after the 16th accept, lanes 0..15 = 1..16.
REQ-031 SHALL cover: then samples 17..24 -> second frame, lanes = 9..24, exactly one frame_valid cycle per frame.
REQ-032 SHALL cover: frame_ready=0 after first frame, feed 8 more -> STALL, sample_ready=0, frame_data still 1..16; 25th offer sets overrun; frame_ready=1 -> lanes 9..24 next cycle, sample_ready=1.
REQ-033 SHALL cover: reset asserted after 10 samples, then 16 new samples 101..116 -> only frame = 101..116, overrun=0.
REQ-034 SHALL cover: macro on, constant 320 x16 -> lane0=320, lanes1..15=10.
REQ-035 SHALL cover: macro on, 32767 then -32768 -> second stored value saturates to -32768.
